// File: rtl/snake_dir_ctrl_if.sv
// Handshake bundle between the input/timer side and the snake direction controller.
interface snake_dir_ctrl_if;
  logic       press_up;
  logic       press_right;
  logic       press_down;
  logic       press_left;
  logic       press_pause;
  logic       tick;
  logic       game_over;
  logic [1:0] dir;
  logic       step;
  logic [1:0] state;
  logic [2:0] q_count;

  modport master (
    output press_up, press_right, press_down, press_left, press_pause, tick, game_over,
    input  dir, step, state, q_count
  );

  modport slave (
    input  press_up, press_right, press_down, press_left, press_pause, tick, game_over,
    output dir, step, state, q_count
  );
endinterface

// File: rtl/snake_dir_ctrl.sv
// Snake heading/step controller: queues turns between ticks, rejects reversals, runs IDLE/RUN/PAUSE/OVER.
// All outputs registered; step follows its tick by one cycle together with the dir update.
module snake_dir_ctrl #(
  parameter int         QDEPTH   = 2,
  parameter logic [1:0] DIR_INIT = 2'b01
) (
  input  logic             clk,
  input  logic             rst,
  snake_dir_ctrl_if.slave  bus
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'b00,
    ST_RUN   = 2'b01,
    ST_PAUSE = 2'b10,
    ST_OVER  = 2'b11
  } state_e;

  state_e     state_q, state_d;
  logic [1:0] dir_q, dir_d;
  logic       step_q, step_d;
  logic [2:0] cnt_q, cnt_d;
  logic [1:0] rd_ptr_q, rd_ptr_d;
  logic [1:0] wr_ptr_q, wr_ptr_d;
  logic [1:0] mem_q [4];

  logic       cand_vld;
  logic [1:0] cand;
  logic [1:0] tail_ptr;
  logic [1:0] ref_dir;
  logic       push_req, pop_req, flush;
  logic       accept, do_push, do_pop;

  function automatic logic [1:0] ptr_inc(input logic [1:0] p);
    return (p == 2'(QDEPTH - 1)) ? 2'd0 : p + 2'd1;
  endfunction

  always_comb begin
    cand_vld = bus.press_up | bus.press_right | bus.press_down | bus.press_left;
    cand     = 2'b11;
    if (bus.press_up)         cand = 2'b00;
    else if (bus.press_right) cand = 2'b01;
    else if (bus.press_down)  cand = 2'b10;
  end

  // Newest queued turn is the reference so chained turns can never fold back on themselves.
  always_comb begin
    tail_ptr = (wr_ptr_q == 2'd0) ? 2'(QDEPTH - 1) : wr_ptr_q - 2'd1;
    ref_dir  = (cnt_q != 3'd0) ? mem_q[tail_ptr] : dir_q;
  end

  always_comb begin
    state_d  = state_q;
    dir_d    = dir_q;
    step_d   = 1'b0;
    push_req = 1'b0;
    pop_req  = 1'b0;
    flush    = 1'b0;

    case (state_q)
      ST_IDLE: begin
        push_req = cand_vld;
        if (cand_vld || bus.press_pause) state_d = ST_RUN;
      end
      ST_RUN: begin
        if (bus.game_over) begin
          state_d = ST_OVER;
          flush   = 1'b1;
        end else begin
          push_req = cand_vld;
          if (bus.press_pause) begin
            state_d = ST_PAUSE;
          end else if (bus.tick) begin
            pop_req = 1'b1;
            step_d  = 1'b1;
          end
        end
      end
      ST_PAUSE: begin
        if (bus.press_pause) state_d = ST_RUN;
      end
      ST_OVER: begin
        if (bus.press_pause) begin
          state_d = ST_IDLE;
          dir_d   = DIR_INIT;
          flush   = 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    accept  = push_req && (cand != ref_dir) && (cand != (ref_dir ^ 2'b10));
    do_pop  = pop_req && (cnt_q != 3'd0);
    do_push = accept && ((cnt_q < 3'(QDEPTH)) || do_pop);

    if (do_pop) dir_d = mem_q[rd_ptr_q];

    cnt_d    = cnt_q + {2'b00, do_push} - {2'b00, do_pop};
    rd_ptr_d = do_pop  ? ptr_inc(rd_ptr_q) : rd_ptr_q;
    wr_ptr_d = do_push ? ptr_inc(wr_ptr_q) : wr_ptr_q;
    if (flush) begin
      cnt_d    = 3'd0;
      rd_ptr_d = 2'd0;
      wr_ptr_d = 2'd0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= ST_IDLE;
      dir_q    <= DIR_INIT;
      step_q   <= 1'b0;
      cnt_q    <= 3'd0;
      rd_ptr_q <= 2'd0;
      wr_ptr_q <= 2'd0;
      for (int i = 0; i < 4; i++) mem_q[i] <= 2'b00;
    end else begin
      state_q  <= state_d;
      dir_q    <= dir_d;
      step_q   <= step_d;
      cnt_q    <= cnt_d;
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      if (do_push) mem_q[wr_ptr_q] <= cand;
    end
  end

  assign bus.dir     = dir_q;
  assign bus.step    = step_q;
  assign bus.state   = state_q;
  assign bus.q_count = cnt_q;

endmodule

// File: tb/tb_snake_dir_ctrl.sv
// Bench for snake_dir_ctrl: directed scenarios plus randomized traffic against a queue-based model.
module tb_snake_dir_ctrl;
  localparam int         QD    = 2;
  localparam logic [1:0] DINIT = 2'b01;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks = 0;
  int   failures = 0;

  always #5 clk = ~clk;

  snake_dir_ctrl_if bus();

  snake_dir_ctrl #(.QDEPTH(QD), .DIR_INIT(DINIT)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  // Reference model: game state, heading, pending step and the turn queue
  int         m_state;
  logic [1:0] m_dir;
  logic       m_step;
  logic [1:0] mq[$];

  task automatic mdl_reset();
    m_state = 0;
    m_dir   = DINIT;
    m_step  = 1'b0;
    mq.delete();
  endtask

  task automatic mdl_apply(input logic up, right, down, left, pause, tick, go);
    logic       any_dir, try_push, try_pop;
    logic [1:0] c, r;
    any_dir  = up | right | down | left;
    c        = up ? 2'd0 : right ? 2'd1 : down ? 2'd2 : 2'd3;
    r        = (mq.size() > 0) ? mq[$] : m_dir;
    try_push = 1'b0;
    try_pop  = 1'b0;
    m_step   = 1'b0;
    case (m_state)
      0: begin
        try_push = any_dir;
        if (any_dir || pause) m_state = 1;
      end
      1: begin
        if (go) begin
          m_state = 3;
          mq.delete();
        end else begin
          try_push = any_dir;
          if (pause) m_state = 2;
          else if (tick) begin
            try_pop = 1'b1;
            m_step  = 1'b1;
          end
        end
      end
      2: if (pause) m_state = 1;
      default: if (pause) begin
        m_state = 0;
        m_dir   = DINIT;
        mq.delete();
      end
    endcase
    if (try_pop && mq.size() > 0) m_dir = mq.pop_front();
    if (try_push && c != r && c != (r ^ 2'b10) && mq.size() < QD) mq.push_back(c);
  endtask

  task automatic cyc(input logic up, right, down, left, pause, tick, go);
    bus.press_up    = up;
    bus.press_right = right;
    bus.press_down  = down;
    bus.press_left  = left;
    bus.press_pause = pause;
    bus.tick        = tick;
    bus.game_over   = go;
    mdl_apply(up, right, down, left, pause, tick, go);
    @(posedge clk);
    #1;
    bus.press_up = 0; bus.press_right = 0; bus.press_down = 0; bus.press_left = 0;
    bus.press_pause = 0; bus.tick = 0; bus.game_over = 0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    bus.press_up = 0; bus.press_right = 0; bus.press_down = 0; bus.press_left = 0;
    bus.press_pause = 0; bus.tick = 0; bus.game_over = 0;
    mdl_reset();
    @(posedge clk);
    #1;
    checks += 4;
    if (bus.state !== 2'b00) begin failures++; $display("FAIL reset_state got=%b exp=00", bus.state); end
    if (bus.dir !== 2'b01) begin failures++; $display("FAIL reset_dir got=%b exp=01", bus.dir); end
    if (bus.step !== 1'b0) begin failures++; $display("FAIL reset_step got=%b exp=0", bus.step); end
    if (bus.q_count !== 3'd0) begin failures++; $display("FAIL reset_qcount got=%0d exp=0", bus.q_count); end
    rst = 1'b0;
  endtask

  task automatic test_start();
    cyc(0, 1, 0, 0, 0, 0, 0);
    checks += 2;
    if (bus.state !== 2'b01) begin failures++; $display("FAIL start_state got=%b exp=01", bus.state); end
    if (bus.q_count !== 3'd0) begin failures++; $display("FAIL start_qcount got=%0d exp=0", bus.q_count); end
    cyc(0, 0, 0, 0, 0, 1, 0);
    checks += 2;
    if (bus.step !== 1'b1) begin failures++; $display("FAIL start_step got=%b exp=1", bus.step); end
    if (bus.dir !== 2'b01) begin failures++; $display("FAIL start_dir got=%b exp=01", bus.dir); end
    cyc(0, 0, 0, 0, 0, 0, 0);
    checks++;
    if (bus.step !== 1'b0) begin failures++; $display("FAIL start_step_clear got=%b exp=0", bus.step); end
  endtask

  task automatic test_reversal();
    cyc(0, 0, 0, 1, 0, 0, 0);
    checks++;
    if (bus.q_count !== 3'd0) begin failures++; $display("FAIL rev_qcount got=%0d exp=0", bus.q_count); end
    cyc(0, 0, 0, 0, 0, 1, 0);
    checks++;
    if (bus.dir !== 2'b01) begin failures++; $display("FAIL rev_dir got=%b exp=01", bus.dir); end
  endtask

  task automatic test_queue();
    cyc(1, 0, 0, 0, 0, 0, 0);
    cyc(0, 0, 0, 1, 0, 0, 0);
    checks++;
    if (bus.q_count !== 3'd2) begin failures++; $display("FAIL queue_fill got=%0d exp=2", bus.q_count); end
    cyc(0, 0, 0, 0, 0, 1, 0);
    checks += 2;
    if (bus.dir !== 2'b00) begin failures++; $display("FAIL queue_tick1_dir got=%b exp=00", bus.dir); end
    if (bus.q_count !== 3'd1) begin failures++; $display("FAIL queue_tick1_cnt got=%0d exp=1", bus.q_count); end
    cyc(0, 0, 0, 0, 0, 1, 0);
    checks += 2;
    if (bus.dir !== 2'b11) begin failures++; $display("FAIL queue_tick2_dir got=%b exp=11", bus.dir); end
    if (bus.q_count !== 3'd0) begin failures++; $display("FAIL queue_tick2_cnt got=%0d exp=0", bus.q_count); end
  endtask

  task automatic test_full();
    cyc(1, 0, 0, 0, 0, 0, 0);
    cyc(0, 0, 0, 1, 0, 0, 0);
    cyc(0, 0, 1, 0, 0, 0, 0);
    checks++;
    if (bus.q_count !== 3'd2) begin failures++; $display("FAIL full_drop got=%0d exp=2", bus.q_count); end
    cyc(0, 0, 1, 0, 0, 1, 0);
    checks += 3;
    if (bus.q_count !== 3'd2) begin failures++; $display("FAIL full_poppush_cnt got=%0d exp=2", bus.q_count); end
    if (bus.dir !== 2'b00) begin failures++; $display("FAIL full_poppush_dir got=%b exp=00", bus.dir); end
    if (bus.step !== 1'b1) begin failures++; $display("FAIL full_poppush_step got=%b exp=1", bus.step); end
    cyc(0, 0, 0, 0, 0, 1, 0);
    cyc(0, 0, 0, 0, 0, 1, 0);
    checks += 2;
    if (bus.dir !== 2'b10) begin failures++; $display("FAIL full_drain_dir got=%b exp=10", bus.dir); end
    if (bus.q_count !== 3'd0) begin failures++; $display("FAIL full_drain_cnt got=%0d exp=0", bus.q_count); end
  endtask

  task automatic test_pause();
    cyc(0, 0, 0, 0, 1, 0, 0);
    checks++;
    if (bus.state !== 2'b10) begin failures++; $display("FAIL pause_state got=%b exp=10", bus.state); end
    for (int i = 0; i < 3; i++) begin
      cyc(0, 0, 0, 0, 0, 1, 0);
      checks += 2;
      if (bus.step !== 1'b0) begin failures++; $display("FAIL pause_step%0d got=%b exp=0", i, bus.step); end
      if (bus.dir !== 2'b10) begin failures++; $display("FAIL pause_dir%0d got=%b exp=10", i, bus.dir); end
    end
    cyc(0, 0, 0, 0, 1, 0, 0);
    checks++;
    if (bus.state !== 2'b01) begin failures++; $display("FAIL resume_state got=%b exp=01", bus.state); end
    cyc(0, 0, 0, 0, 0, 1, 0);
    checks++;
    if (bus.step !== 1'b1) begin failures++; $display("FAIL resume_step got=%b exp=1", bus.step); end
  endtask

  task automatic test_over_and_rst();
    cyc(0, 1, 0, 0, 0, 0, 0);
    cyc(0, 0, 0, 0, 0, 1, 1);
    checks += 3;
    if (bus.state !== 2'b11) begin failures++; $display("FAIL over_state got=%b exp=11", bus.state); end
    if (bus.step !== 1'b0) begin failures++; $display("FAIL over_step got=%b exp=0", bus.step); end
    if (bus.q_count !== 3'd0) begin failures++; $display("FAIL over_qcount got=%0d exp=0", bus.q_count); end
    cyc(1, 0, 0, 0, 0, 1, 0);
    checks++;
    if (bus.state !== 2'b11) begin failures++; $display("FAIL over_hold got=%b exp=11", bus.state); end
    cyc(0, 0, 0, 0, 1, 0, 0);
    checks += 2;
    if (bus.state !== 2'b00) begin failures++; $display("FAIL restart_state got=%b exp=00", bus.state); end
    if (bus.dir !== 2'b01) begin failures++; $display("FAIL restart_dir got=%b exp=01", bus.dir); end
    cyc(1, 0, 0, 0, 0, 0, 0);
    checks += 2;
    if (bus.state !== 2'b01) begin failures++; $display("FAIL restart_run got=%b exp=01", bus.state); end
    if (bus.q_count !== 3'd1) begin failures++; $display("FAIL restart_push got=%0d exp=1", bus.q_count); end
    cyc(0, 0, 0, 0, 0, 1, 0);
    cyc(0, 1, 0, 0, 0, 0, 0);
    #2;
    rst = 1'b1;
    #1;
    checks += 4;
    if (bus.state !== 2'b00) begin failures++; $display("FAIL arst_state got=%b exp=00", bus.state); end
    if (bus.dir !== 2'b01) begin failures++; $display("FAIL arst_dir got=%b exp=01", bus.dir); end
    if (bus.step !== 1'b0) begin failures++; $display("FAIL arst_step got=%b exp=0", bus.step); end
    if (bus.q_count !== 3'd0) begin failures++; $display("FAIL arst_qcount got=%0d exp=0", bus.q_count); end
    mdl_reset();
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;
  endtask

  task automatic test_random();
    logic up, rt, dn, lf, pa, tk, go;
    for (int i = 0; i < 600; i++) begin
      up = ($urandom_range(0, 5) == 0);
      rt = ($urandom_range(0, 5) == 0);
      dn = ($urandom_range(0, 5) == 0);
      lf = ($urandom_range(0, 5) == 0);
      pa = ($urandom_range(0, 24) == 0);
      tk = ($urandom_range(0, 3) == 0);
      go = ($urandom_range(0, 59) == 0);
      cyc(up, rt, dn, lf, pa, tk, go);
      checks += 4;
      if (bus.state !== 2'(m_state)) begin
        failures++; $display("FAIL rand_state cyc=%0d got=%b exp=%b", i, bus.state, 2'(m_state));
      end
      if (bus.dir !== m_dir) begin
        failures++; $display("FAIL rand_dir cyc=%0d got=%b exp=%b", i, bus.dir, m_dir);
      end
      if (bus.step !== m_step) begin
        failures++; $display("FAIL rand_step cyc=%0d got=%b exp=%b", i, bus.step, m_step);
      end
      if (bus.q_count !== 3'(mq.size())) begin
        failures++; $display("FAIL rand_qcount cyc=%0d got=%0d exp=%0d", i, bus.q_count, mq.size());
      end
    end
  endtask

  initial begin
    test_reset();
    test_start();
    test_reversal();
    test_queue();
    test_full();
    test_pause();
    test_over_and_rst();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
